// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the registered immediate/load-data extender:
// extension mode encodings and the output-buffer occupancy states.
package ext_pipe_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        EXT_ZERO = 3'b000,  // zero-extend imm
        EXT_SIGN = 3'b001,  // sign-extend imm
        EXT_LUI  = 3'b010,  // imm in the upper bits, low bits cleared
        EXT_LBU  = 3'b011,  // selected byte, zero-extended
        EXT_LB   = 3'b100,  // selected byte, sign-extended
        EXT_LHU  = 3'b101,  // selected halfword, zero-extended
        EXT_LH   = 3'b110,  // selected halfword, sign-extended
        EXT_WORD = 3'b111   // word passed through
    } ext_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/ext_pipe_if.sv
// Producer/consumer bundle of the extender: input item with its handshake,
// synchronous flush, and the output item with its handshake.
interface ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    import ext_pipe_pkg::*;

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [MODE_W-1:0]    mode;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    word;
    logic [OFF_W-1:0]     byte_off;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_err;

    // Upstream stage / downstream stage view (drives items, consumes results).
    modport master (
        output flush, in_valid, mode, imm, word, byte_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    // Extender view.
    modport slave (
        input  flush, in_valid, mode, imm, word, byte_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_comb.sv
// Pure combinational mode/offset extractor. Bytes are little-endian
// (byte k = word[8k+7:8k]); halfwords are taken at byte_off with its low
// bit forced to 0.
// Optional macro EXT_PIPE_ALIGN_CHECK_EN: an odd byte_off in a halfword
// mode yields err=1 and data=0 instead of silently aligning down.
module ext_comb
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  byte_off,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [OFF_W-1:0] half_off;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;

    assign half_off = byte_off & ~OFF_W'(1);
    assign sel_byte = word[{byte_off, 3'b000} +: 8];
    assign sel_half = word[{half_off, 3'b000} +: 16];

    // Select and extend the field named by mode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        data = '0;
        err  = 1'b0;
        case (ext_mode_e'(mode))
            EXT_ZERO: data = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_SIGN: data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            EXT_LUI:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_LBU:  data = {{(DATA_W-8){1'b0}}, sel_byte};
            EXT_LB:   data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            EXT_LHU:  data = {{(DATA_W-16){1'b0}}, sel_half};
            EXT_LH:   data = {{(DATA_W-16){sel_half[15]}}, sel_half};
            EXT_WORD: data = word;
            default:  data = '0;
        endcase
`ifdef EXT_PIPE_ALIGN_CHECK_EN
        if ((mode == EXT_LHU || mode == EXT_LH) && byte_off[0]) begin
            data = '0;
            err  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate/load-data extender with a 2-entry valid/ready output
// buffer (head = output register, skid = second entry). in_ready is a
// register, so no combinational path runs from out_ready to in_ready.
// Optional macro EXT_PIPE_ALIGN_CHECK_EN enables the misaligned-halfword
// error flag in ext_comb; otherwise out_err is always 0.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    ext_pipe_if.slave bus
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [DATA_W-1:0] in_data;
    logic              in_err;
    logic [DATA_W-1:0] head_data;
    logic              head_err;
    logic [DATA_W-1:0] skid_data;
    logic              skid_err;

    occ_e state;
    occ_e state_nxt;
    logic in_ready_q;
    logic accept;
    logic pop;
    logic load_head_in;
    logic load_head_skid;
    logic load_skid;

    ext_comb #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_comb (
        .mode     (bus.mode),
        .imm      (bus.imm),
        .word     (bus.word),
        .byte_off (bus.byte_off),
        .data     (in_data),
        .err      (in_err)
    );

    assign accept        = bus.in_valid & in_ready_q;
    assign pop           = (state != EMPTY) & bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = head_data;
    assign bus.out_err   = head_err;

    // Occupancy transitions and entry load enables; flush overrides all.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_head_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) begin
            state_nxt      = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Occupancy register and registered in_ready (low only while full).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // Buffer entries; head holds its value whenever it is not reloaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data entries are reset too, because out_data and
            // out_err must read 0 after reset even though out_valid is 0.
            head_data <= '0;
            head_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_data <= in_data;
                head_err  <= in_err;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_err  <= in_err;
            end
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: constant vector table, hand-written
// handshake/flush/reset sequences, and a randomized run against a
// queue-based reference model.
module tb_ext_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [31:0] word;
        logic [1:0]  off;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } item_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    ext_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

    ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.mode     = 3'b000;
        bus.imm      = '0;
        bus.word     = '0;
        bus.byte_off = '0;
    endtask

    task automatic drive(input logic [2:0] m, input logic [15:0] im,
                         input logic [31:0] w, input logic [1:0] off);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.imm      = im;
        bus.word     = w;
        bus.byte_off = off;
    endtask

    // Reference extension computed from the mode definitions with plain arithmetic.
    function automatic item_t ref_ext(input logic [2:0] m, input logic [15:0] im,
                                      input logic [31:0] w, input logic [1:0] off);
        item_t       r;
        logic [31:0] b;
        logic [31:0] h;
        int          hoff;
        hoff   = int'(off) & 2;
        b      = (w >> (8 * int'(off))) & 32'h0000_00FF;
        h      = (w >> (8 * hoff)) & 32'h0000_FFFF;
        r.err  = 1'b0;
        case (m)
            3'd0: r.data = 32'(im);
            3'd1: r.data = im[15] ? (32'hFFFF_0000 | 32'(im)) : 32'(im);
            3'd2: r.data = 32'(im) << 16;
            3'd3: r.data = b;
            3'd4: r.data = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd5: r.data = h;
            3'd6: r.data = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            default: r.data = w;
        endcase
`ifdef EXT_PIPE_ALIGN_CHECK_EN
        if ((m == 3'd5 || m == 3'd6) && off[0]) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end
`endif
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] got[$];
        item_t       q[$];
        item_t       it;
        logic [31:0] v;
        logic        acc;
        logic        pop;
        logic        held;

        vecs[0] = '{"lb_off1",   3'b100, 16'h0000, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0};
        vecs[1] = '{"lb_off2",   3'b100, 16'h0000, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{"lbu_off3",  3'b011, 16'h0000, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0};
        vecs[3] = '{"lh_off2",   3'b110, 16'h0000, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0};
        vecs[4] = '{"lui",       3'b010, 16'h1234, 32'h80FF7F01, 2'd0, 32'h12340000, 1'b0};
        vecs[5] = '{"zext",      3'b000, 16'h8001, 32'h0,        2'd0, 32'h00008001, 1'b0};
        vecs[6] = '{"word",      3'b111, 16'h0000, 32'h80FF7F01, 2'd3, 32'h80FF7F01, 1'b0};
        vecs[7] = '{"lhu_off2",  3'b101, 16'h0000, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0};
        vecs[8] = '{"lbu_off0",  3'b011, 16'h0000, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0};
`ifdef EXT_PIPE_ALIGN_CHECK_EN
        vecs[9] = '{"lh_off1",   3'b110, 16'h0000, 32'h80FF7F01, 2'd1, 32'h00000000, 1'b1};
`else
        vecs[9] = '{"lh_off1",   3'b110, 16'h0000, 32'h80FF7F01, 2'd1, 32'h00007F01, 1'b0};
`endif

        // Reset state.
        idle();
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single item, one-cycle latency.
        bus.out_ready = 1'b1;
        check("single_in_ready", 32'(bus.in_ready), 32'd1);
        drive(3'b001, 16'h8001, 32'h0, 2'd0);
        tick();
        bus.in_valid = 1'b0;
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data",  bus.out_data,       32'hFFFF8001);
        tick();
        check("single_drain", 32'(bus.out_valid), 32'd0);

        // Mode sweep table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].mode, vecs[i].imm, vecs[i].word, vecs[i].off);
            tick();
            bus.in_valid = 1'b0;
            check({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({vecs[i].name, "_data"},  bus.out_data,       vecs[i].exp_data);
            check({vecs[i].name, "_err"},   32'(bus.out_err),   32'(vecs[i].exp_err));
            tick();
        end

        // Backpressure: three items into a two-entry buffer.
        bus.out_ready = 1'b0;
        drive(3'b000, 16'd1, 32'h0, 2'd0);
        tick();
        check("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        drive(3'b000, 16'd2, 32'h0, 2'd0);
        tick();
        check("bp_ready_after2", 32'(bus.in_ready), 32'd0);
        drive(3'b000, 16'd3, 32'h0, 2'd0);
        tick();
        check("bp_ready_held", 32'(bus.in_ready), 32'd0);
        check("bp_head_held",  bus.out_data,      32'd1);
        bus.out_ready = 1'b1;
        got = {};
        for (int c = 0; c < 10; c++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) got.push_back(bus.out_data);
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        check("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            v = (i < got.size()) ? got[i] : 32'hDEADDEAD;
            check($sformatf("bp_order%0d", i), v, 32'(i + 1));
        end

        // Streaming: accept and pop every cycle.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(3'b000, 16'(i + 16), 32'h0, 2'd0);
            else       bus.in_valid = 1'b0;
            check($sformatf("stream_ready%0d", i), 32'(bus.in_ready), 32'd1);
            if (i > 0) begin
                check($sformatf("stream_valid%0d", i), 32'(bus.out_valid), 32'd1);
                check($sformatf("stream_data%0d", i),  bus.out_data,       32'(i + 15));
            end
            tick();
        end
        check("stream_drain", 32'(bus.out_valid), 32'd0);

        // Flush while full with a concurrent in_valid.
        bus.out_ready = 1'b0;
        drive(3'b000, 16'h41, 32'h0, 2'd0);
        tick();
        drive(3'b000, 16'h42, 32'h0, 2'd0);
        tick();
        check("flush2_full", 32'(bus.in_ready), 32'd0);
        drive(3'b000, 16'h43, 32'h0, 2'd0);
        bus.flush = 1'b1;
        tick();
        idle();
        check("flush2_valid", 32'(bus.out_valid), 32'd0);
        check("flush2_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("flush2_quiet%0d", c), 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Flush with one entry and a same-cycle accept: the accept is discarded.
        bus.out_ready = 1'b0;
        drive(3'b000, 16'h44, 32'h0, 2'd0);
        tick();
        drive(3'b000, 16'h45, 32'h0, 2'd0);
        bus.flush = 1'b1;
        tick();
        idle();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("flush1_quiet%0d", c), 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        bus.out_ready = 1'b0;
        drive(3'b110, 16'h0, 32'h8000_0000, 2'd2);
        tick();
        check("mid_loaded", bus.out_data, 32'hFFFF8000);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        check("mid_rst_data",  bus.out_data,       32'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("mid_after_valid", 32'(bus.out_valid), 32'd0);

        // Randomized traffic against the queue model.
        q = {};
        held = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            check("rnd_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("rnd_ready", 32'(bus.in_ready),  32'(q.size() < 2));
            if (q.size() != 0) begin
                check("rnd_data", bus.out_data,     q[0].data);
                check("rnd_err",  32'(bus.out_err), 32'(q[0].err));
            end
            if (!held) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.mode     = 3'($urandom_range(0, 7));
                bus.imm      = 16'($urandom);
                bus.word     = $urandom;
                bus.byte_off = 2'($urandom_range(0, 3));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            acc = bus.in_valid && (q.size() < 2);
            pop = (q.size() != 0) && bus.out_ready;
            if (pop) void'(q.pop_front());
            if (bus.flush) begin
                q.delete();
            end else if (acc) begin
                it = ref_ext(bus.mode, bus.imm, bus.word, bus.byte_off);
                q.push_back(it);
            end
            held = bus.in_valid && !acc;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Registered, parametrised immediate/load-data extender for the MIPS pipeline.
- Generalises the combinational extender in three ways:
  - configurable data and immediate widths;
  - additional load byte/halfword extraction modes (lb/lbu/lh/lhu) selected by byte offset;
  - a 2-entry valid/ready output buffer with synchronous flush, so it can sit between the DM read and W-stage without combinational ready paths.

Parameters:
- DATA_W, 32, output/word width; multiple of 8, >= 2*IMM_W
- IMM_W, 16, immediate width
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush; discards buffered and incoming items
- in_valid  in  1  input item present
- in_ready  out  1  buffer can accept; registered
- mode  in  3  extension mode (see Behaviour)
- imm  in  IMM_W  immediate field
- word  in  DATA_W  loaded memory word
- byte_off  in  OFF_W  byte address within word
- out_valid  out  1  output item present
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  extended result
- out_err  out  1  misaligned-halfword flag for this item

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid=0, out_data=0, out_err=0, in_ready=1;
  - occupancy=EMPTY, both entries cleared.
- Modes (result computed combinationally at input, stored on accept):
  - 000: zero-extend imm.
  - 001: sign-extend imm (bit IMM_W-1).
  - 010: imm placed in the top IMM_W bits, lower bits 0 (lui).
  - 011: lbu — byte byte_off of word, zero-extended.
  - 100: lb — same byte, sign-extended.
  - 101: lhu — 16-bit half at byte_off (low bit forced 0), zero-extended.
  - 110: lh — same half, sign-extended.
  - 111: word passed through unchanged.
- Byte numbering: little-endian; byte k = word[8k+7:8k].
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Producer may not drop in_valid or change data while in_valid & !in_ready.
- Latency: 1 cycle from accept to out_valid; throughput 1 item/cycle when out_ready stays high.
- Occupancy state machine (head = output register, skid = second entry):
  - EMPTY: accept -> ONE (head loaded).
  - ONE:
    - accept & !pop -> TWO (skid loaded);
    - accept & pop -> ONE (head reloaded with new item);
    - pop & !accept -> EMPTY;
    - else hold.
  - TWO:
    - pop -> ONE (skid moves to head);
    - no accept is possible in TWO.
- in_ready is registered: next in_ready = (next state != TWO).
- Ordering: strictly FIFO; skid item is never output before head.
- out_data/out_err hold their value while out_valid & !out_ready.
- When out_valid=0, out_data/out_err keep their last value and must be ignored; after reset both are 0.
- Flush:
  - next state EMPTY, in_ready=1, out_valid=0 next cycle;
  - a same-cycle accept is discarded;
  - a same-cycle pop completes normally.
- Flush asserted together with reset: reset wins.
- Reset deassertion mid-stream: bench must hold in_valid=0 for the first cycle after release.

Optional Feature:
- Macro: EXT_PIPE_ALIGN_CHECK_EN.
- Defined:
  - modes 101/110 with byte_off[0]=1 produce out_err=1 and out_data=0 (for the exception unit);
  - all other modes give out_err=0.
- Undefined:
  - out_err tied 0;
  - byte_off[0] ignored for halfword modes (aligned down);
  - the error logic is not built.

Decomposition:
- Shared package: mode encoding constants (EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_LBU, EXT_LB, EXT_LHU, EXT_LH, EXT_WORD).
- Same package: occupancy state encoding (EMPTY/ONE/TWO).
- One sub-module: ext_comb — the pure combinational mode/offset extractor (mode, imm, word, byte_off -> data, err).
- ext_pipe instantiates ext_comb and adds the 2-entry buffer.

Test Plan:
- Reset then single item, out_ready=1: mode=001, imm=16'h8001 -> in_ready=1 after reset; out_valid one cycle later with out_data=32'hFFFF8001.
- Mode sweep, word=32'h80FF7F01:
  - lb off=1 -> 32'h0000007F
  - lb off=2 -> 32'hFFFFFFFF
  - lbu off=3 -> 32'h00000080
  - lh off=2 -> 32'hFFFF80FF
  - lui imm=16'h1234 -> 32'h12340000
- Backpressure: out_ready=0, send 3 items (imm=1,2,3, mode 000) -> in_ready drops after 2nd accept; 3rd held; raising out_ready yields 1,2,3 in order, no loss or duplication.
- Simultaneous accept+pop in ONE, streaming 8 items with out_ready=1 -> one output per cycle, state stays ONE, in_ready constantly 1.
- Flush in TWO with a concurrent in_valid -> next cycle out_valid=0, in_ready=1, and no item from before or at the flush ever appears.
- With EXT_PIPE_ALIGN_CHECK_EN: lh off=1 -> out_err=1, out_data=0. Without the macro, the same stimulus -> out_err=0, out_data equals the off=0 half, sign-extended.
